flowstate_rmw_ctrl: RTL and testbench
=====================================

// Module: flowstate_rmw_ctrl
// PURPOSE
//  Sequences read-modify-write updates on the flowstate RAM for the reliable-send MAU.
//  Accepts one update request at a time, reads the current flowstate, applies the opcode,
//  writes the result back and drives the broadcast port (bcd_*) that other flowstate RAM copies consume.
//  Fully serialised (one op in flight), so same-address hazards cannot occur.
// PARAMETERS
//  VALUE_WIDTH     32  flowstate / argument width
//  ADDR_WIDTH      10  flowstate RAM address width
//  CNT_WIDTH       32  width of the update/skip statistics counters
//  SKIP_UNCHANGED  1   1: no RAM write/broadcast when new value == old value
// PORTS
//  clk              in   1      clock
//  rst              in   1      synchronous reset, active-high
//  s_upd_addr       in   ADDR   flowstate address to update
//  s_upd_op         in   2      0 SET, 1 ADD, 2 MAX, 3 CLRBITS
//  s_upd_arg        in   VALUE  operand
//  s_upd_valid      in   1      request valid
//  s_upd_ready      out  1      request accepted when valid&&ready
//  ram_rden         out  1      RAM read enable
//  ram_raddr        out  ADDR   RAM read address
//  ram_rdata        in   VALUE  RAM read data, valid exactly 1 cycle after ram_rden
//  ram_wren         out  1      RAM write enable
//  ram_waddr        out  ADDR   RAM write address
//  ram_wdata        out  VALUE  RAM write data
//  bcd_valid_out    out  1      broadcast strobe (equal to ram_wren)
//  bcd_addr_out     out  ADDR   broadcast address (equal to ram_waddr)
//  bcd_flowstate_out out VALUE  broadcast data (equal to ram_wdata)
//  m_upd_old        out  VALUE  flowstate before the update
//  m_upd_new        out  VALUE  flowstate after the update
//  m_upd_written    out  1      1 if the op wrote the RAM, 0 if skipped
//  m_upd_valid      out  1      response valid
//  m_upd_ready      in   1      response accepted when valid&&ready
//  upd_count        out  CNT    number of writes performed, saturating
//  skip_count       out  CNT    number of skipped writes, saturating
// BEHAVIOUR
//  - Reset: state=IDLE; s_upd_ready=1; ram_rden=ram_wren=bcd_valid_out=0; m_upd_valid=0;
//    m_upd_written=0; data/addr outputs=0; counters=0. Reset mid-op aborts the op and performs no write.
//  - FSM IDLE->RD->CALC->WR->(RESP)->IDLE. s_upd_ready=1 only in IDLE.
//  - IDLE: on valid&&ready, assert ram_rden=1 and ram_raddr=s_upd_addr combinationally in the same cycle;
//    register addr/op/arg; go to RD.
//  - RD: capture ram_rdata into old; compute new (registered); go to CALC.
//    SET: new=arg. ADD: new=(old+arg) mod 2^VALUE_WIDTH (wraps, no saturation).
//    MAX: new=unsigned max(old,arg). CLRBITS: new=old & ~arg.
//  - CALC: go to WR. Registered outputs ram_wren/bcd_valid_out=1 in WR unless SKIP_UNCHANGED && new==old.
//  - WR: single-cycle write+broadcast pulse (never longer than 1 cycle). m_upd_valid=1 with old/new/written.
//    Increment upd_count if written, else skip_count; both hold at all-ones.
//    If m_upd_ready in WR: go to IDLE; otherwise go to RESP.
//  - RESP: hold m_upd_* stable; no RAM activity; go to IDLE when m_upd_ready.
//  - Latency: accept@T -> write/broadcast and response@T+3. Next accept@T+4 at the earliest
//    (minimum 4 cycles per op).
//  - ram_rden is asserted only in IDLE on accept; ram_wren is asserted only in WR; they are never both
//    high in the same cycle.
// TESTING
//  1 ADD: RAM[5]=10, op ADD arg 3 -> rden@T addr 5; wren@T+3 addr5 data13; bcd matches; old=10 new=13 written=1.
//  2 Wrap: RAM[0]=0xFFFFFFFF, ADD 2 -> new=0x00000001, written=1.
//  3 Skip: RAM[7]=20, MAX 15, SKIP_UNCHANGED=1 -> no wren/bcd; old=new=20, written=0; skip_count=1.
//  4 Backpressure: m_upd_ready=0 for 5 cycles -> response held stable; s_upd_ready=0; a single 1-cycle wren only;
//    op2 accepted the cycle after the ready handshake.
//  5 Back-to-back same addr: SET 9 @addr3, then CLRBITS 0x1 @addr3 -> second op reads 9, writes 8.
//  6 Reset during CALC -> no wren/bcd; all outputs at reset values next cycle; next request proceeds normally.

Source files
------------

// File: rtl/flowstate_rmw_if.sv
// flowstate_rmw_if: request, RAM, broadcast, response and statistics signals of the flowstate RMW controller.
interface flowstate_rmw_if #(
    parameter int VALUE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10,
    parameter int CNT_WIDTH   = 32
);
    logic [ADDR_WIDTH-1:0]  s_upd_addr;
    logic [1:0]             s_upd_op;
    logic [VALUE_WIDTH-1:0] s_upd_arg;
    logic                   s_upd_valid;
    logic                   s_upd_ready;
    logic                   ram_rden;
    logic [ADDR_WIDTH-1:0]  ram_raddr;
    logic [VALUE_WIDTH-1:0] ram_rdata;
    logic                   ram_wren;
    logic [ADDR_WIDTH-1:0]  ram_waddr;
    logic [VALUE_WIDTH-1:0] ram_wdata;
    logic                   bcd_valid_out;
    logic [ADDR_WIDTH-1:0]  bcd_addr_out;
    logic [VALUE_WIDTH-1:0] bcd_flowstate_out;
    logic [VALUE_WIDTH-1:0] m_upd_old;
    logic [VALUE_WIDTH-1:0] m_upd_new;
    logic                   m_upd_written;
    logic                   m_upd_valid;
    logic                   m_upd_ready;
    logic [CNT_WIDTH-1:0]   upd_count;
    logic [CNT_WIDTH-1:0]   skip_count;

    modport slave (
        input  s_upd_addr, s_upd_op, s_upd_arg, s_upd_valid, ram_rdata, m_upd_ready,
        output s_upd_ready, ram_rden, ram_raddr, ram_wren, ram_waddr, ram_wdata,
               bcd_valid_out, bcd_addr_out, bcd_flowstate_out,
               m_upd_old, m_upd_new, m_upd_written, m_upd_valid, upd_count, skip_count
    );

    modport master (
        output s_upd_addr, s_upd_op, s_upd_arg, s_upd_valid, ram_rdata, m_upd_ready,
        input  s_upd_ready, ram_rden, ram_raddr, ram_wren, ram_waddr, ram_wdata,
               bcd_valid_out, bcd_addr_out, bcd_flowstate_out,
               m_upd_old, m_upd_new, m_upd_written, m_upd_valid, upd_count, skip_count
    );
endinterface

// File: rtl/flowstate_rmw_ctrl.sv
// flowstate_rmw_ctrl: serialised read-modify-write sequencer for the flowstate RAM, broadcasting every write.
module flowstate_rmw_ctrl #(
    parameter int VALUE_WIDTH    = 32,
    parameter int ADDR_WIDTH     = 10,
    parameter int CNT_WIDTH      = 32,
    parameter bit SKIP_UNCHANGED = 1'b1
) (
    input logic            clk,
    input logic            rst,
    flowstate_rmw_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, CALC, WR, RESP} state_t;
    state_t                 state, state_n;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [1:0]             op_q;
    logic [VALUE_WIDTH-1:0] arg_q, old_q, new_q, calc;
    logic                   written_q;
    logic [CNT_WIDTH-1:0]   upd_q, skip_q;
    logic                   accept;

    assign accept = state == IDLE && bus.s_upd_valid;

    always_comb
        calc = op_q == 2'd0 ? arg_q :
               op_q == 2'd1 ? bus.ram_rdata + arg_q :
               op_q == 2'd2 ? (bus.ram_rdata > arg_q ? bus.ram_rdata : arg_q) :
                              bus.ram_rdata & ~arg_q;

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_n;

    always_comb begin
        state_n         = state;
        bus.s_upd_ready = 1'b0;
        bus.ram_rden    = 1'b0;
        bus.ram_raddr   = '0;
        bus.ram_wren    = 1'b0;
        bus.m_upd_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.s_upd_ready = 1'b1;
                bus.ram_rden    = bus.s_upd_valid;
                bus.ram_raddr   = bus.s_upd_valid ? bus.s_upd_addr : '0;
                state_n         = bus.s_upd_valid ? RD : IDLE;
            end
            RD:   state_n = CALC;
            CALC: state_n = WR;
            WR: begin
                bus.ram_wren    = written_q;
                bus.m_upd_valid = 1'b1;
                state_n         = bus.m_upd_ready ? IDLE : RESP;
            end
            RESP: begin
                bus.m_upd_valid = 1'b1;
                state_n         = bus.m_upd_ready ? IDLE : RESP;
            end
            default: state_n = IDLE;
        endcase
    end

    // old/new stay frozen from RD until the next accept, so they double as the response payload
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            op_q      <= '0;
            arg_q     <= '0;
            old_q     <= '0;
            new_q     <= '0;
            written_q <= 1'b0;
            upd_q     <= '0;
            skip_q    <= '0;
        end else begin
            if (accept) begin
                addr_q <= bus.s_upd_addr;
                op_q   <= bus.s_upd_op;
                arg_q  <= bus.s_upd_arg;
            end
            if (state == RD) begin
                old_q <= bus.ram_rdata;
                new_q <= calc;
            end
            if (state == CALC)
                written_q <= !(SKIP_UNCHANGED && new_q == old_q);
            if (state == WR && written_q)
                upd_q <= upd_q + CNT_WIDTH'(~&upd_q);
            if (state == WR && !written_q)
                skip_q <= skip_q + CNT_WIDTH'(~&skip_q);
        end
    end

    assign bus.ram_waddr         = addr_q;
    assign bus.ram_wdata         = new_q;
    assign bus.bcd_valid_out     = bus.ram_wren;
    assign bus.bcd_addr_out      = addr_q;
    assign bus.bcd_flowstate_out = new_q;
    assign bus.m_upd_old         = old_q;
    assign bus.m_upd_new         = new_q;
    assign bus.m_upd_written     = written_q;
    assign bus.upd_count         = upd_q;
    assign bus.skip_count        = skip_q;
endmodule

// File: tb/tb_flowstate_rmw_ctrl.sv
// tb_flowstate_rmw_ctrl: directed and random RMW traffic against a RAM model and a per-cycle reference model.
module tb_flowstate_rmw_ctrl;
    localparam logic [1:0] SET = 2'd0, ADD = 2'd1, MAX = 2'd2, CLR = 2'd3;
    localparam bit SKIP = 1'b1;

    logic clk, rst;
    int   bp_mode;
    int   checks, errors, cyc;

    logic [31:0] mem     [1024];
    logic [31:0] ref_mem [1024];

    bit          busy, just_rst, e_wr;
    int          t_acc, acc_cyc, prev_acc, hs_cyc;
    int          wren_pulses, resp_cyc, hs_wren_pulses, hs_resp, last_wr_age;
    logic [9:0]  e_addr, last_rd_addr, last_waddr;
    logic [31:0] e_old, e_new, last_old, last_new, last_wdata, m_upd, m_skip;
    logic        last_written;

    flowstate_rmw_if #(.VALUE_WIDTH(32), .ADDR_WIDTH(10), .CNT_WIDTH(32)) bus ();

    flowstate_rmw_ctrl #(.VALUE_WIDTH(32), .ADDR_WIDTH(10), .CNT_WIDTH(32), .SKIP_UNCHANGED(SKIP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_val(input int i);
        return (32'(i) * 32'd2654435761) ^ 32'h5a5a;
    endfunction

    function automatic logic [31:0] apply(input logic [1:0] o, input logic [31:0] old, input logic [31:0] arg);
        case (o)
            SET:     return arg;
            ADD:     return old + arg;
            MAX:     return old > arg ? old : arg;
            default: return old & ~arg;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // synchronous-read RAM behind the controller
    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_val(i);
        bus.ram_rdata = '0;
        forever begin
            @(posedge clk);
            if (bus.ram_rden) bus.ram_rdata <= mem[bus.ram_raddr];
            if (bus.ram_wren) mem[bus.ram_waddr] = bus.ram_wdata;
        end
    end

    initial begin
        bus.m_upd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.m_upd_ready = bp_mode == 1 ? 1'b0 : bp_mode == 2 ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // reference model and per-cycle compare
    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                busy = 0; m_upd = 0; m_skip = 0; just_rst = 1;
            end else begin
                if (just_rst) begin
                    just_rst = 0;
                    chk("rst_s_ready", bus.s_upd_ready, 1);
                    chk("rst_wren", bus.ram_wren, 0);
                    chk("rst_bcd_valid", bus.bcd_valid_out, 0);
                    chk("rst_m_valid", bus.m_upd_valid, 0);
                    chk("rst_written", bus.m_upd_written, 0);
                    chk("rst_old", bus.m_upd_old, 0);
                    chk("rst_new", bus.m_upd_new, 0);
                    chk("rst_waddr", bus.ram_waddr, 0);
                    chk("rst_wdata", bus.ram_wdata, 0);
                    chk("rst_upd_count", bus.upd_count, 0);
                    chk("rst_skip_count", bus.skip_count, 0);
                end
                chk("rd_wr_exclusive", bus.ram_rden & bus.ram_wren, 0);
                chk("bcd_valid", bus.bcd_valid_out, bus.ram_wren);
                chk("bcd_addr", bus.bcd_addr_out, bus.ram_waddr);
                chk("bcd_data", bus.bcd_flowstate_out, bus.ram_wdata);
                if (!busy) begin
                    chk("s_ready_idle", bus.s_upd_ready, 1);
                    chk("wren_idle", bus.ram_wren, 0);
                    chk("m_valid_idle", bus.m_upd_valid, 0);
                    chk("upd_count", bus.upd_count, m_upd);
                    chk("skip_count", bus.skip_count, m_skip);
                    chk("rden", bus.ram_rden, bus.s_upd_valid);
                    if (bus.s_upd_valid) begin
                        chk("raddr", bus.ram_raddr, bus.s_upd_addr);
                        busy = 1; prev_acc = acc_cyc; acc_cyc = cyc; t_acc = cyc;
                        e_addr = bus.s_upd_addr;
                        e_old = ref_mem[e_addr];
                        e_new = apply(bus.s_upd_op, e_old, bus.s_upd_arg);
                        e_wr = !(SKIP && e_new == e_old);
                        last_rd_addr = bus.ram_raddr;
                        wren_pulses = 0; resp_cyc = 0; last_wr_age = 0;
                    end
                end else begin
                    automatic int age = cyc - t_acc;
                    chk("s_ready_busy", bus.s_upd_ready, 0);
                    chk("rden_busy", bus.ram_rden, 0);
                    chk("wren", bus.ram_wren, age == 3 && e_wr);
                    chk("m_valid", bus.m_upd_valid, age >= 3);
                    wren_pulses += int'(bus.ram_wren);
                    resp_cyc += int'(bus.m_upd_valid);
                    if (bus.ram_wren) begin
                        last_wr_age = age; last_waddr = bus.ram_waddr; last_wdata = bus.ram_wdata;
                        chk("waddr", bus.ram_waddr, e_addr);
                        chk("wdata", bus.ram_wdata, e_new);
                    end
                    if (age >= 3) begin
                        chk("m_old", bus.m_upd_old, e_old);
                        chk("m_new", bus.m_upd_new, e_new);
                        chk("m_written", bus.m_upd_written, e_wr);
                    end
                    if (age == 3) begin
                        last_old = bus.m_upd_old; last_new = bus.m_upd_new; last_written = bus.m_upd_written;
                        if (e_wr) begin
                            ref_mem[e_addr] = e_new;
                            if (m_upd != '1) m_upd++;
                        end else if (m_skip != '1) m_skip++;
                    end
                    if (age >= 3 && bus.m_upd_ready) begin
                        busy = 0; hs_cyc = cyc; hs_wren_pulses = wren_pulses; hs_resp = resp_cyc;
                    end
                end
            end
        end
    end

    task automatic do_op(input logic [9:0] a, input logic [1:0] o, input logic [31:0] g);
        logic acc;
        int   n;
        acc = 0; n = 0;
        bus.s_upd_addr = a; bus.s_upd_op = o; bus.s_upd_arg = g; bus.s_upd_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = bus.s_upd_ready;
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", acc, 1);
        bus.s_upd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        rst = 1'b1; bp_mode = 2;
        bus.s_upd_valid = 1'b0; bus.s_upd_addr = '0; bus.s_upd_op = '0; bus.s_upd_arg = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        do_op(10'd5, SET, 32'd10); wait_idle();
        do_op(10'd5, ADD, 32'd3); wait_idle();
        chk("t1_rd_addr", last_rd_addr, 5);
        chk("t1_wr_age", last_wr_age, 3);
        chk("t1_waddr", last_waddr, 5);
        chk("t1_wdata", last_wdata, 13);
        chk("t1_old", last_old, 10);
        chk("t1_new", last_new, 13);
        chk("t1_written", last_written, 1);

        do_op(10'd0, SET, 32'hFFFF_FFFF); wait_idle();
        do_op(10'd0, ADD, 32'd2); wait_idle();
        chk("t2_old", last_old, 32'hFFFF_FFFF);
        chk("t2_new", last_new, 32'h0000_0001);
        chk("t2_written", last_written, 1);

        do_op(10'd7, SET, 32'd20); wait_idle();
        do_op(10'd7, MAX, 32'd15); wait_idle();
        chk("t3_old", last_old, 20);
        chk("t3_new", last_new, 20);
        chk("t3_written", last_written, 0);
        chk("t3_wren_pulses", hs_wren_pulses, 0);
        chk("t3_skip_count", bus.skip_count, 1);
        chk("t3_upd_count", bus.upd_count, 5);

        bp_mode = 1;
        do_op(10'd11, ADD, 32'd100);
        bus.s_upd_addr = 10'd12; bus.s_upd_op = SET; bus.s_upd_arg = 32'h1234; bus.s_upd_valid = 1'b1;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        bp_mode = 2;
        do_op(10'd12, SET, 32'h1234);
        chk("t4_wren_pulses", hs_wren_pulses, 1);
        chk("t4_resp_cycles", hs_resp, 6);
        chk("t4_accept_gap", acc_cyc - hs_cyc, 1);
        wait_idle();
        chk("t4_op2_new", last_new, 32'h1234);

        do_op(10'd3, SET, 32'd9);
        do_op(10'd3, CLR, 32'd1);
        chk("t5_accept_gap", acc_cyc - prev_acc, 4);
        wait_idle();
        chk("t5_old", last_old, 9);
        chk("t5_new", last_new, 8);

        do_op(10'd9, SET, 32'h55);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        do_op(10'd9, ADD, 32'd0); wait_idle();
        chk("t6_old", last_old, init_val(9));
        chk("t6_written", last_written, 0);
        chk("t6_skip_count", bus.skip_count, 1);
        chk("t6_upd_count", bus.upd_count, 0);

        bp_mode = 0;
        for (int k = 0; k < 200; k++) begin
            do_op(10'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 1) ? 32'($urandom_range(0, 40)) : 32'($urandom));
            if ($urandom_range(0, 3) == 0)
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk);
                    #1;
                end
        end
        bp_mode = 2;
        wait_idle();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
